// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
// Shared definitions for the RV32I instruction encoder:
//   - RV32I major opcodes and fixed funct3 values (same constants the main
//     control decoder matches against)
//   - request operation-class encoding (req_op)
//   - encoder FSM state encoding
//   - captured request record
package instr_encoder_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;   // lw / sw width
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Operation class on req_op; codes 6 and 7 are reserved and produce a nop.
    typedef enum logic [2:0] {
        OP_LW   = 3'd0,
        OP_SW   = 3'd1,
        OP_R    = 3'd2,
        OP_BEQ  = 3'd3,
        OP_IALU = 3'd4,
        OP_JAL  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } req_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    // Request fields as captured on acceptance.
    typedef struct packed {
        req_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [20:0] imm;
    } enc_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Request handshake plus instruction-memory write port of the encoder.
//   req_*      : encode request from the loader (valid/ready handshake)
//   imem_*     : single-word write port towards instruction memory
// Modports: master = loader / bench side, slave = encoder side.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [20:0]       req_imm;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer
// Combinational packer: operation class + register/immediate fields ->
// 32-bit RV32I word, plus an immediate range-violation flag.
// Ports:
//   req     in   captured request record
//   word    out  encoded instruction (nop for reserved op codes)
//   imm_bad out  immediate does not fit the selected format
// Macro IMM_RANGE_CHECK_EN: when defined, imm_bad reports range/alignment
// violations; otherwise imm_bad is 0 and the immediate is truncated.
module imm_packer
    import instr_encoder_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        imm_bad
);

    always_comb begin
        word = NOP_WORD;
        case (req.op)
            OP_LW:   word = {req.imm[11:0], req.rs1, F3_WORD, req.rd, OPC_LOAD};
            OP_SW:   word = {req.imm[11:5], req.rs2, req.rs1, F3_WORD,
                             req.imm[4:0], OPC_STORE};
            OP_R:    word = {1'b0, req.funct7b5, 5'b00000, req.rs2, req.rs1,
                             req.funct3, req.rd, OPC_OP};
            OP_IALU: word = {req.imm[11:0], req.rs1, req.funct3, req.rd, OPC_OP_IMM};
            OP_BEQ:  word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                             req.imm[4:1], req.imm[11], OPC_BRANCH};
            OP_JAL:  word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                             req.rd, OPC_JAL};
            default: word = NOP_WORD;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A value sign-fits N bits when every bit from N-1 upward equals the sign.
    logic fits12, fits13;
    assign fits12 = (&req.imm[20:11]) | ~(|req.imm[20:11]);
    assign fits13 = (&req.imm[20:12]) | ~(|req.imm[20:12]);

    always_comb begin
        imm_bad = 1'b0;
        case (req.op)
            OP_LW, OP_SW, OP_IALU: imm_bad = ~fits12;
            OP_BEQ:                imm_bad = ~fits13 | req.imm[0];
            OP_JAL:                imm_bad = req.imm[0];
            default:               imm_bad = 1'b0;
        endcase
    end
`else
    // Branch/jump offsets are halfword aligned, so bit 0 is simply dropped.
    logic unused_imm0;
    assign unused_imm0 = req.imm[0];
    assign imm_bad     = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Packs encode requests into RV32I words and writes them sequentially into
// instruction memory. FSM IDLE -> ENC -> WR -> IDLE: fields are captured on
// acceptance, ENC registers the encoded word, WR strobes the write.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       restart program: pointer to BASE_ADDR, count to 0, abort word
//   bus         instr_encoder_if.slave: request handshake + imem write port
//   count       words written since reset/start
//   full        count reached capacity (2**ADDR_W); no wrap-around
//   busy        FSM not in IDLE
//   imm_err     1-cycle pulse when an immediate is rejected
// Macro IMM_RANGE_CHECK_EN enables immediate range checking (see imm_packer);
// without it imm_err never asserts.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              imm_err
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    enc_req_t          req_q, req_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_bad;
    logic              req_ready;
    logic              kill;

    imm_packer u_packer (
        .req     (req_q),
        .word    (enc_word),
        .imm_bad (enc_bad)
    );

    assign full      = (count_q == CAPACITY);
    assign req_ready = (state_q == ST_IDLE) && !full && !start;

    // The WR strobe is registered, so start/reset arriving in the WR cycle
    // itself must mask it to keep the aborted word out of memory.
    assign kill = start | ~rst_n;

    assign bus.req_ready  = req_ready;
    assign bus.imem_we    = we_q & ~kill;
    assign bus.imem_addr  = ptr_q;
    assign bus.imem_wdata = wdata_q;
    assign imm_err        = err_q & ~kill;
    assign count          = count_q;
    assign busy           = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    req_d.op       = req_op_e'(bus.req_op);
                    req_d.rd       = bus.req_rd;
                    req_d.rs1      = bus.req_rs1;
                    req_d.rs2      = bus.req_rs2;
                    req_d.funct3   = bus.req_funct3;
                    req_d.funct7b5 = bus.req_funct7b5;
                    req_d.imm      = bus.req_imm;
                    state_d        = ST_ENC;
                end
            end
            ST_ENC: begin
                wdata_d = enc_word;
                we_d    = ~enc_bad;
                err_d   = enc_bad;
                state_d = ST_WR;
            end
            ST_WR: begin
                // A rejected immediate leaves pointer and count untouched.
                if (we_q) begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_IDLE;
            ptr_d   = BASE;
            count_d = '0;
            we_d    = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            ptr_q   <= BASE;
            count_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Self-checking bench for instr_encoder (ADDR_W=2, capacity 4 words).
// Expected words come from a bit-arithmetic model of the RV32I formats.
// Honours IMM_RANGE_CHECK_EN in its model when compiled with it.
module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [AW:0] count;
    logic        full, busy, imm_err;

    int checks = 0;
    int errors = 0;
    int m_ptr   = 0;
    int m_count = 0;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .busy    (busy),
        .imm_err (imm_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned bitv(input int unsigned v, input int b);
        return (v >> b) & 1;
    endfunction

    function automatic logic [31:0] model_word(input int op, input int unsigned rd,
            input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
            input int unsigned f7, input int unsigned v);
        int unsigned w;
        case (op)
            0: w = ((v & 'hFFF) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03;
            1: w = (((v >> 5) & 'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                   + ((v & 'h1F) << 7) + 'h23;
            2: w = (f7 << 30) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            3: w = (bitv(v, 12) << 31) + (((v >> 5) & 'h3F) << 25) + (rs2 << 20)
                   + (rs1 << 15) + (((v >> 1) & 'hF) << 8) + (bitv(v, 11) << 7) + 'h63;
            4: w = ((v & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
            5: w = (bitv(v, 20) << 31) + (((v >> 1) & 'h3FF) << 21) + (bitv(v, 11) << 20)
                   + (((v >> 12) & 'hFF) << 12) + (rd << 7) + 'h6F;
            default: w = 'h13;
        endcase
        return w;
    endfunction

    function automatic bit model_bad(input int op, input int unsigned v);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = (v >= (1 << 20)) ? int'(v) - (1 << 21) : int'(v);
        case (op)
            0, 1, 4: return (s < -2048 || s > 2047);
            3:       return (s < -4096 || s > 4095 || (s % 2) != 0);
            5:       return (v % 2) != 0;
            default: return 1'b0;
        endcase
`else
        return (op < 0) && (v == 0);  // never true: no range checking in this build
`endif
    endfunction

    // ---------------- tasks ----------------
    // Called at a negedge (or just after a posedge); ends at the negedge of
    // the IDLE cycle that follows the write.
    task automatic do_start();
        start = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL start_ready: req_ready=%b expected 0", bus.req_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        m_ptr = 0; m_count = 0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_state: count=%0d full=%b busy=%b expected 0 0 0", count, full, busy);
        end
    endtask

    task automatic issue(input string nm, input int op, input int unsigned rd,
            input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
            input int unsigned f7, input int unsigned imm, input logic [31:0] exp_w,
            input bit exp_bad);
        int n;
        if (m_count == CAP) do_start();
        bus.req_op = 3'(op); bus.req_rd = 5'(rd); bus.req_rs1 = 5'(rs1);
        bus.req_rs2 = 5'(rs2); bus.req_funct3 = 3'(f3); bus.req_funct7b5 = 1'(f7);
        bus.req_imm = 21'(imm); bus.req_valid = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_timeout: req_ready=%b expected 1", nm, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);   // ENC
        checks++;
        if (bus.imem_we !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s enc: we=%b busy=%b expected 0 1", nm, bus.imem_we, busy);
        end
        @(negedge clk);   // WR
        if (exp_bad) begin
            checks++;
            if (imm_err !== 1'b1 || bus.imem_we !== 1'b0) begin
                errors++; $display("FAIL %s imm_err: err=%b we=%b expected 1 0", nm, imm_err, bus.imem_we);
            end
        end else begin
            checks++;
            if (bus.imem_we !== 1'b1 || imm_err !== 1'b0) begin
                errors++; $display("FAIL %s we: we=%b err=%b expected 1 0", nm, bus.imem_we, imm_err);
            end
            checks++;
            if (bus.imem_addr !== AW'(m_ptr)) begin
                errors++; $display("FAIL %s addr: got %0d expected %0d", nm, bus.imem_addr, m_ptr);
            end
            checks++;
            if (bus.imem_wdata !== exp_w) begin
                errors++; $display("FAIL %s wdata: got %08h expected %08h", nm, bus.imem_wdata, exp_w);
            end
            m_ptr = (m_ptr + 1) % CAP;
            m_count++;
        end
        @(negedge clk);   // back in IDLE
        checks++;
        if (count !== (AW + 1)'(m_count) || full !== (m_count == CAP) || busy !== 1'b0
            || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s post: count=%0d full=%b busy=%b we=%b expected %0d %b 0 0",
                     nm, count, full, busy, bus.imem_we, m_count, (m_count == CAP));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || bus.imem_wdata !== 32'h0 || imm_err !== 1'b0 ||
            busy !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset: we=%b wdata=%08h err=%b busy=%b count=%0d full=%b expected all 0",
                     bus.imem_we, bus.imem_wdata, imm_err, busy, count, full);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 0; m_count = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        issue("lw",  0, 5, 2, 0, 0, 0, 8,  32'h00812283, 1'b0);
        issue("sw",  1, 0, 2, 6, 0, 0, 12, 32'h00612623, 1'b0);
        issue("add", 2, 1, 2, 3, 0, 0, 0,  32'h003100B3, 1'b0);
        issue("sub", 2, 1, 2, 3, 0, 1, 0,  32'h403100B3, 1'b0);
        issue("beq", 3, 0, 1, 2, 0, 0, 32'h1FFFFC, 32'hFE208EE3, 1'b0);
        issue("jal", 5, 1, 0, 0, 0, 0, 8,  32'h008000EF, 1'b0);
        issue("inv6", 6, 7, 8, 9, 1, 1, 5, 32'h00000013, 1'b0);
    endtask

    task automatic test_imm_range();
        issue("ialu2048", 4, 0, 0, 0, 0, 0, 2048, 32'h80000013, model_bad(4, 2048));
    endtask

    task automatic test_full();
        do_start();
        for (int i = 0; i < CAP; i++)
            issue("b2b", 2, i + 1, i + 2, i + 3, i, 0, 0,
                  model_word(2, i + 1, i + 2, i + 3, i, 0, 0), 1'b0);
        // 5th request is held off while full
        bus.req_op = 3'd0; bus.req_rd = 5'd9; bus.req_rs1 = 5'd3; bus.req_imm = 21'd16;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0 || count !== 3'd4) begin
                errors++;
                $display("FAIL full_hold: ready=%b we=%b count=%0d expected 0 0 4",
                         bus.req_ready, bus.imem_we, count);
            end
        end
        do_start();
        issue("after_start", 0, 9, 3, 0, 0, 0, 16, model_word(0, 9, 3, 0, 0, 0, 16), 1'b0);
    endtask

    task automatic test_start_in_enc();
        bus.req_op = 3'd0; bus.req_rd = 5'd1; bus.req_rs1 = 5'd1; bus.req_imm = 21'd4;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_enc: we=%b busy=%b expected 0 1", bus.imem_we, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        m_ptr = 0; m_count = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_we !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL start_enc_after: we=%b busy=%b count=%0d expected 0 0 0",
                         bus.imem_we, busy, count);
            end
        end
    endtask

    task automatic test_reset_in_wr();
        issue("pre_rst", 4, 3, 4, 0, 7, 0, 100, model_word(4, 3, 4, 0, 7, 0, 100), 1'b0);
        bus.req_op = 3'd2; bus.req_rd = 5'd2; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;  // now in WR
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0) begin
            errors++; $display("FAIL rst_wr_we: we=%b expected 0", bus.imem_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 0; m_count = 0;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || bus.imem_wdata !== 32'h0 || imm_err !== 1'b0 ||
            busy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL rst_wr_state: we=%b wdata=%08h err=%b busy=%b count=%0d expected all 0",
                     bus.imem_we, bus.imem_wdata, imm_err, busy, count);
        end
    endtask

    task automatic test_random();
        int op;
        int unsigned rd, rs1, rs2, f3, f7, imm;
        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 7));
            rd  = $urandom_range(0, 31); rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31); f3  = $urandom_range(0, 7);
            f7  = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       imm = ($urandom_range(0, 4095) - 2048) & 'h1FFFFF;
                1:       imm = (($urandom_range(0, 4095) - 2048) * 2) & 'h1FFFFF;
                default: imm = $urandom & 'h1FFFFF;
            endcase
            issue("rand", op, rd, rs1, rs2, f3, f7, imm,
                  model_word(op, rd, rs1, rs2, f3, f7, imm), model_bad(op, imm));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0; bus.req_rs1 = '0;
        bus.req_rs2 = '0; bus.req_funct3 = '0; bus.req_funct7b5 = 1'b0; bus.req_imm = '0;
        test_reset();
        test_directed();
        test_imm_range();
        test_full();
        test_start_in_enc();
        test_reset_in_wr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
